// File: rtl/counter_ctrl_pkg.sv
// Shared types and default width for the counter sequencing controller.
package counter_ctrl_pkg;

  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/count_core.sv
// N-bit binary counter datapath; synchronous clear has priority over enable.
module count_core
  import counter_ctrl_pkg::*;
#(
  parameter int N = CNT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         enable,
  output logic [N-1:0] count
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] count_q;
  logic [N-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_ctrl.sv
// Run sequencer for an enable counter: one-shot/periodic runs with pause,
// abort, terminal tick and one-shot done pulses; drives count_core by clear/enable.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int N = CNT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         pause,
  input  logic         abort,
  input  logic         periodic,
  input  logic [N-1:0] period,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         tick,
  output logic         done
);

  ctrl_state_t  state_q, state_d;
  logic [N-1:0] period_q, period_d;
  logic         periodic_q, periodic_d;
  logic         busy_q, busy_d;
  logic         tick_q, tick_d;
  logic         done_q, done_d;
  logic         cnt_clear;
  logic         cnt_enable;
  logic [N-1:0] cnt_val;

  count_core #(.N(N)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .count   (cnt_val)
  );

  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    periodic_d = periodic_q;
    tick_d     = 1'b0;
    done_d     = 1'b0;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_clear = 1'b1;
        if (start && (period != '0)) begin
          state_d    = RUN;
          period_d   = period;
          periodic_d = periodic;
        end
      end
      RUN: begin
        // abort outranks pause, and pause outranks the terminal count
        if (abort) begin
          cnt_clear = 1'b1;
          state_d   = IDLE;
        end else if (pause) begin
          state_d = HOLD;
        end else if (cnt_val == period_q) begin
          cnt_clear = 1'b1;
          tick_d    = 1'b1;
          if (!periodic_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_enable = 1'b1;
        end
      end
      HOLD: begin
        // resuming spends its edge on the state change, not on counting
        if (abort) begin
          cnt_clear = 1'b1;
          state_d   = IDLE;
        end else if (!pause) begin
          state_d = RUN;
        end
      end
      default: begin
        cnt_clear = 1'b1;
        state_d   = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      period_q   <= '0;
      periodic_q <= 1'b0;
      busy_q     <= 1'b0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      periodic_q <= periodic_d;
      busy_q     <= busy_d;
      tick_q     <= tick_d;
      done_q     <= done_d;
    end
  end

  assign count = cnt_val;
  assign busy  = busy_q;
  assign tick  = tick_q;
  assign done  = done_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: directed vector table, corner sequences,
// async reset and randomized traffic against a run-level reference model.
module tb_counter_ctrl;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start, pause, abort, periodic;
  logic [N-1:0] period;
  logic [N-1:0] count;
  logic         busy, tick, done;

  int n_checks = 0;
  int n_fail   = 0;

  counter_ctrl #(.N(N)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .pause    (pause),
    .abort    (abort),
    .periodic (periodic),
    .period   (period),
    .count    (count),
    .busy     (busy),
    .tick     (tick),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Reference: a run is either inactive, counting or held.
  bit m_active, m_held, m_prd, m_tick, m_done;
  int m_cnt, m_per;

  task automatic model_reset();
    m_active = 0; m_held = 0; m_prd = 0; m_tick = 0; m_done = 0;
    m_cnt = 0; m_per = 0;
  endtask

  task automatic model_step();
    m_tick = 0;
    m_done = 0;
    if (!m_active) begin
      m_cnt = 0;
      if (start && period != 0) begin
        m_active = 1; m_held = 0; m_per = int'(period); m_prd = periodic;
      end
    end else if (abort) begin
      m_active = 0; m_held = 0; m_cnt = 0;
    end else if (m_held) begin
      if (!pause) m_held = 0;
    end else if (pause) begin
      m_held = 1;
    end else if (m_cnt == m_per) begin
      m_cnt = 0; m_tick = 1;
      if (!m_prd) begin
        m_done = 1; m_active = 0;
      end
    end else begin
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("model_count", 32'(count), 32'(m_cnt));
    check("model_busy", 32'(busy), 32'(m_active));
    check("model_tick", 32'(tick), 32'(m_tick));
    check("model_done", 32'(done), 32'(m_done));
  endtask

  task automatic idle_inputs();
    start = 0; pause = 0; abort = 0; periodic = 0; period = '0;
  endtask

  typedef struct {
    bit       st, ps, ab, pd;
    int       per;
    int       e_cnt;
    bit       e_busy, e_tick, e_done;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit st, bit ps, bit ab, bit pd, int per,
                              int e_cnt, bit e_busy, bit e_tick, bit e_done);
    vec_t v;
    v.st = st; v.ps = ps; v.ab = ab; v.pd = pd; v.per = per;
    v.e_cnt = e_cnt; v.e_busy = e_busy; v.e_tick = e_tick; v.e_done = e_done;
    tbl.push_back(v);
  endfunction

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    model_reset();
    #2;
    check("reset_count", 32'(count), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_tick", 32'(tick), 0);
    check("reset_done", 32'(done), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // one-shot P=3
    add(1,0,0,0,3, 0,1,0,0);
    add(0,0,0,0,0, 1,1,0,0);
    add(0,0,0,0,0, 2,1,0,0);
    add(0,0,0,0,0, 3,1,0,0);
    add(0,0,0,0,0, 0,0,1,1);
    add(0,0,0,0,0, 0,0,0,0);
    // start with period 0 is ignored
    add(1,0,0,0,0, 0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0);
    // periodic P=2, ignored restart mid-run, abort on a terminal edge
    add(1,0,0,1,2, 0,1,0,0);
    add(0,0,0,0,0, 1,1,0,0);
    add(0,0,0,0,0, 2,1,0,0);
    add(0,0,0,0,0, 0,1,1,0);
    add(0,0,0,0,0, 1,1,0,0);
    add(0,0,0,0,0, 2,1,0,0);
    add(0,0,0,0,0, 0,1,1,0);
    add(1,0,0,0,7, 1,1,0,0);
    add(0,0,0,0,0, 2,1,0,0);
    add(0,0,1,0,0, 0,0,0,0);
    // one-shot P=4 with a 3-cycle pause at 2 and a pause on the terminal edge
    add(1,0,0,0,4, 0,1,0,0);
    add(0,0,0,0,0, 1,1,0,0);
    add(0,0,0,0,0, 2,1,0,0);
    add(0,1,0,0,0, 2,1,0,0);
    add(0,1,0,0,0, 2,1,0,0);
    add(0,1,0,0,0, 2,1,0,0);
    add(0,0,0,0,0, 2,1,0,0);
    add(0,0,0,0,0, 3,1,0,0);
    add(0,0,0,0,0, 4,1,0,0);
    add(0,1,0,0,0, 4,1,0,0);
    add(0,0,0,0,0, 4,1,0,0);
    add(0,0,0,0,0, 0,0,1,1);
    // abort at count 5 of P=9, then abort while idle
    add(1,0,0,0,9, 0,1,0,0);
    for (int k = 1; k <= 5; k++) add(0,0,0,0,0, k,1,0,0);
    add(0,0,1,0,0, 0,0,0,0);
    add(0,0,1,0,0, 0,0,0,0);

    foreach (tbl[i]) begin
      start = tbl[i].st; pause = tbl[i].ps; abort = tbl[i].ab;
      periodic = tbl[i].pd; period = N'(tbl[i].per);
      cycle();
      check($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      check($sformatf("vec%0d_tick", i), 32'(tick), 32'(tbl[i].e_tick));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].e_done));
    end

    // full-scale period: reaches 31 then returns to 0 without wrapping
    idle_inputs();
    start = 1; period = 5'd31;
    cycle();
    idle_inputs();
    period = 5'd3;
    repeat (31) cycle();
    check("p31_top", 32'(count), 31);
    cycle();
    check("p31_back_to_zero", 32'(count), 0);
    check("p31_tick", 32'(tick), 1);
    check("p31_done", 32'(done), 1);

    // async reset in the middle of a run clears outputs before the next edge
    start = 1; period = 5'd10; periodic = 1;
    cycle();
    idle_inputs();
    repeat (4) cycle();
    check("pre_reset_count", 32'(count), 4);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_count", 32'(count), 0);
    check("async_busy", 32'(busy), 0);
    check("async_tick", 32'(tick), 0);
    check("async_done", 32'(done), 0);
    #2;
    reset_n = 1'b1;
    model_reset();
    start = 1; period = 5'd2; periodic = 0;
    cycle();
    check("restart_busy", 32'(busy), 1);
    idle_inputs();
    repeat (3) cycle();
    check("restart_done", 32'(done), 1);

    // randomized traffic against the reference
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 3) == 0);
      pause    = ($urandom_range(0, 7) == 0);
      abort    = ($urandom_range(0, 40) == 0);
      periodic = $urandom_range(0, 1);
      period   = ($urandom_range(0, 9) == 0) ? N'($urandom) : N'($urandom_range(0, 6));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
